// File: rtl/seq_div_restoring_if.sv
// Start/busy/done handshake and operand/result bus for the restoring divider.
// The requester drives the master side; the divider implements the slave side.
interface seq_div_restoring_if #(
    parameter int DATA_SIZE = 4
);
    logic                 start_in;
    logic [DATA_SIZE-1:0] dividend_in;
    logic [DATA_SIZE-1:0] divisor_in;
    logic [DATA_SIZE-1:0] quotient_out;
    logic [DATA_SIZE-1:0] remainder_out;
    logic                 busy_out;
    logic                 done_out;
    logic                 div_by_zero_out;

    modport master (
        output start_in, dividend_in, divisor_in,
        input  quotient_out, remainder_out, busy_out, done_out, div_by_zero_out
    );

    modport slave (
        input  start_in, dividend_in, divisor_in,
        output quotient_out, remainder_out, busy_out, done_out, div_by_zero_out
    );
endinterface

// File: rtl/seq_div_restoring.sv
// Iterative unsigned restoring divider: one quotient bit per clock, MSB first,
// trial subtraction done as R + ~D + 1. Results hold until the next accepted start.
module seq_div_restoring #(
    parameter int DATA_SIZE = 4
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    seq_div_restoring_if.slave bus
);
    localparam int CNT_W = $clog2(DATA_SIZE + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t               state, state_nxt;
    logic [DATA_SIZE-1:0] dvd, dvd_nxt;
    logic [DATA_SIZE-1:0] dvs, dvs_nxt;
    logic [DATA_SIZE-1:0] q, q_nxt;
    logic [DATA_SIZE:0]   r, r_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic [DATA_SIZE-1:0] quo, quo_nxt;
    logic [DATA_SIZE-1:0] rem, rem_nxt;
    logic                 busy, busy_nxt;
    logic                 done, done_nxt;
    logic                 dbz, dbz_nxt;

    logic [DATA_SIZE:0]   r_sh;
    logic [DATA_SIZE:0]   t;
    logic [DATA_SIZE:0]   r_sel;
    logic [DATA_SIZE-1:0] q_sh;

    function automatic logic [DATA_SIZE:0] trial_sub(input logic [DATA_SIZE:0] a,
                                                     input logic [DATA_SIZE-1:0] b);
        return a + ~{1'b0, b} + (DATA_SIZE + 1)'(1);
    endfunction

    // One restoring step: MSB of T set means a borrow, so keep the shifted R.
    always_comb begin
        r_sh  = {r[DATA_SIZE-1:0], dvd[DATA_SIZE-1]};
        t     = trial_sub(r_sh, dvs);
        r_sel = t[DATA_SIZE] ? r_sh : t;
        q_sh  = {q[DATA_SIZE-2:0], ~t[DATA_SIZE]};
    end

    always_comb begin
        state_nxt = state;
        dvd_nxt   = dvd;
        dvs_nxt   = dvs;
        q_nxt     = q;
        r_nxt     = r;
        cnt_nxt   = cnt;
        quo_nxt   = quo;
        rem_nxt   = rem;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        dbz_nxt   = dbz;

        case (state)
            CALC: begin
                dvd_nxt = {dvd[DATA_SIZE-2:0], 1'b0};
                q_nxt   = q_sh;
                r_nxt   = r_sel;
                if (cnt == CNT_W'(DATA_SIZE - 1)) begin
                    state_nxt = DONE;
                    quo_nxt   = q_sh;
                    rem_nxt   = r_sel[DATA_SIZE-1:0];
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                // IDLE and the DONE cycle both accept a new request.
                if (bus.start_in) begin
                    if (bus.divisor_in != '0) begin
                        state_nxt = CALC;
                        dvd_nxt   = bus.dividend_in;
                        dvs_nxt   = bus.divisor_in;
                        q_nxt     = '0;
                        r_nxt     = '0;
                        cnt_nxt   = '0;
                        busy_nxt  = 1'b1;
                        dbz_nxt   = 1'b0;
                    end else begin
                        state_nxt = DONE;
                        quo_nxt   = '1;
                        rem_nxt   = bus.dividend_in;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                        dbz_nxt   = 1'b1;
                    end
                end else begin
                    state_nxt = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state <= IDLE;
            dvd   <= '0;
            dvs   <= '0;
            q     <= '0;
            r     <= '0;
            cnt   <= '0;
            quo   <= '0;
            rem   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            dbz   <= 1'b0;
        end else begin
            state <= state_nxt;
            dvd   <= dvd_nxt;
            dvs   <= dvs_nxt;
            q     <= q_nxt;
            r     <= r_nxt;
            cnt   <= cnt_nxt;
            quo   <= quo_nxt;
            rem   <= rem_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
            dbz   <= dbz_nxt;
        end
    end

    assign bus.quotient_out    = quo;
    assign bus.remainder_out   = rem;
    assign bus.busy_out        = busy;
    assign bus.done_out        = done;
    assign bus.div_by_zero_out = dbz;
endmodule

// File: tb/tb_seq_div_restoring.sv
// Bench for seq_div_restoring: directed cases followed by random operations,
// compared with plain integer division and the fixed start-to-done latency.
module tb_seq_div_restoring;
    localparam int N = 4;
    localparam int ALL_ONES = (1 << N) - 1;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    seq_div_restoring_if #(.DATA_SIZE(N)) bus ();

    seq_div_restoring #(.DATA_SIZE(N)) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present a request; the accepting edge is the next rising edge.
    task automatic start_op(input int a, input int b);
        @(negedge clk);
        bus.start_in    = 1'b1;
        bus.dividend_in = N'(a);
        bus.divisor_in  = N'(b);
    endtask

    // Follows one accepted request through to its done cycle. With hold set,
    // start_in stays high so the caller can chain the next request in the
    // done cycle; poke >= 0 raises start_in with 1/1 during that busy cycle.
    task automatic expect_result(input string tag, input int a, input int b,
                                 input bit hold, input int poke);
        int exp_q;
        int exp_r;
        exp_q = (b == 0) ? ALL_ONES : a / b;
        exp_r = (b == 0) ? a : a % b;
        @(negedge clk);
        if (!hold) bus.start_in = 1'b0;
        bus.dividend_in = N'($urandom);
        bus.divisor_in  = N'($urandom);
        if (b != 0) begin
            for (int i = 0; i < N; i++) begin
                if (i > 0) @(negedge clk);
                check({tag, ".busy"}, 32'(bus.busy_out), 1);
                check({tag, ".done_early"}, 32'(bus.done_out), 0);
                if (!hold) begin
                    bus.start_in = (i == poke);
                    if (i == poke) begin
                        bus.dividend_in = N'(1);
                        bus.divisor_in  = N'(1);
                    end
                end
            end
            @(negedge clk);
        end
        if (!hold) bus.start_in = 1'b0;
        check({tag, ".done"}, 32'(bus.done_out), 1);
        check({tag, ".busy_end"}, 32'(bus.busy_out), 0);
        check({tag, ".q"}, 32'(bus.quotient_out), 32'(exp_q));
        check({tag, ".r"}, 32'(bus.remainder_out), 32'(exp_r));
        check({tag, ".dbz"}, 32'(bus.div_by_zero_out), (b == 0) ? 1 : 0);
    endtask

    // Cycle after a done with start_in low: pulse gone, results held.
    task automatic idle_check(input string tag, input int a, input int b);
        @(negedge clk);
        check({tag, ".done_drop"}, 32'(bus.done_out), 0);
        check({tag, ".q_hold"}, 32'(bus.quotient_out), 32'((b == 0) ? ALL_ONES : a / b));
        check({tag, ".r_hold"}, 32'(bus.remainder_out), 32'((b == 0) ? a : a % b));
    endtask

    initial begin
        int a;
        int b;
        bit chain;
        bit chained;
        int seen_done;

        rst_n           = 1'b0;
        bus.start_in    = 1'b0;
        bus.dividend_in = '0;
        bus.divisor_in  = '0;
        repeat (2) @(negedge clk);
        check("reset.q", 32'(bus.quotient_out), 0);
        check("reset.r", 32'(bus.remainder_out), 0);
        check("reset.busy", 32'(bus.busy_out), 0);
        check("reset.done", 32'(bus.done_out), 0);
        check("reset.dbz", 32'(bus.div_by_zero_out), 0);
        rst_n = 1'b1;

        start_op(13, 3);  expect_result("d13_3", 13, 3, 0, -1);  idle_check("d13_3", 13, 3);
        start_op(15, 1);  expect_result("d15_1", 15, 1, 0, -1);  idle_check("d15_1", 15, 1);
        start_op(5, 7);   expect_result("d5_7", 5, 7, 0, -1);    idle_check("d5_7", 5, 7);
        start_op(0, 9);   expect_result("d0_9", 0, 9, 0, -1);    idle_check("d0_9", 0, 9);
        start_op(15, 15); expect_result("d15_15", 15, 15, 0, -1); idle_check("d15_15", 15, 15);
        start_op(9, 0);   expect_result("d9_0", 9, 0, 0, -1);    idle_check("d9_0", 9, 0);
        start_op(8, 2);   expect_result("d8_2", 8, 2, 0, -1);    idle_check("d8_2", 8, 2);

        start_op(14, 4);  expect_result("busy_start", 14, 4, 0, 1); idle_check("busy_start", 14, 4);

        start_op(12, 5);
        expect_result("b2b_first", 12, 5, 1, -1);
        bus.dividend_in = N'(7);
        bus.divisor_in  = N'(2);
        expect_result("b2b_second", 7, 2, 0, -1);
        idle_check("b2b_second", 7, 2);

        start_op(11, 2);
        @(negedge clk);
        bus.start_in = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid.q", 32'(bus.quotient_out), 0);
        check("rst_mid.r", 32'(bus.remainder_out), 0);
        check("rst_mid.busy", 32'(bus.busy_out), 0);
        check("rst_mid.done", 32'(bus.done_out), 0);
        check("rst_mid.dbz", 32'(bus.div_by_zero_out), 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 0;
        for (int i = 0; i < N + 3; i++) begin
            @(negedge clk);
            if (bus.done_out || bus.busy_out) seen_done++;
        end
        check("rst_mid.no_done", 32'(seen_done), 0);
        start_op(11, 2);  expect_result("after_rst", 11, 2, 0, -1); idle_check("after_rst", 11, 2);

        chained = 1'b0;
        for (int k = 0; k < 40; k++) begin
            a = int'($urandom_range(0, ALL_ONES));
            b = int'($urandom_range(0, ALL_ONES));
            if (k % 9 == 4) b = 0;
            chain = (k == 39) ? 1'b0 : 1'($urandom_range(0, 1));
            if (!chained) @(negedge clk);
            bus.start_in    = 1'b1;
            bus.dividend_in = N'(a);
            bus.divisor_in  = N'(b);
            expect_result("rand", a, b, chain, -1);
            if (!chain) idle_check("rand", a, b);
            chained = chain;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
